// File: rtl/button_gesture_pkg.sv
// Shared definitions for the button gesture decoder: event codes, FSM states
// and an elaboration-time helper for sizing the gesture timer.
package button_gesture_pkg;

  localparam logic [1:0] EV_CLICK  = 2'd0;
  localparam logic [1:0] EV_DOUBLE = 2'd1;
  localparam logic [1:0] EV_LONG   = 2'd2;
  localparam logic [1:0] EV_REPEAT = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_t;

  function automatic bit timer_fits(input int w, input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m < (1 << w);
  endfunction

endpackage

// File: rtl/button_gesture_tick_divider.sv
// Free-running power-of-two prescaler; tick pulses for one cycle as the count wraps.
module button_gesture_tick_divider #(
  parameter int TICK_LOG2 = 16
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  logic [TICK_LOG2-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count <= '0;
    else       count <= count + TICK_LOG2'(1);
  end

  assign tick = &count;

endmodule

// File: rtl/button_gesture.sv
// Debounced active-low push button to CLICK/DOUBLE/LONG events behind a valid/ack register.
// Define BUTTON_GESTURE_REPEAT_EN to also emit REPEAT events while the button stays held after LONG.
//   state  | meaning
//   IDLE   | released, no gesture in progress
//   PRESS1 | first press held, waiting for release or LONG
//   GAP    | released after first press, waiting for second press or CLICK timeout
//   PRESS2 | second press held, release gives DOUBLE
//   HOLD   | LONG already reported, waiting for release
module button_gesture
  import button_gesture_pkg::*;
#(
  parameter int DELAY        = 2,
  parameter int TICK_LOG2    = 16,
  parameter int LONG_TICKS   = 40,
  parameter int GAP_TICKS    = 15,
  parameter int REPEAT_TICKS = 10,
  parameter int TIMER_W      = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       signal_pin,
  output logic       pressed,
  output logic       event_valid,
  output logic [1:0] event_code,
  input  logic       event_ack,
  output logic       overflow
);

  localparam logic [TIMER_W-1:0] LONG_T = TIMER_W'(LONG_TICKS);
  localparam logic [TIMER_W-1:0] GAP_T  = TIMER_W'(GAP_TICKS);

  if (!timer_fits(TIMER_W, LONG_TICKS, GAP_TICKS, REPEAT_TICKS)) begin : g_timer_w_check
    $error("button_gesture: TIMER_W too narrow for the tick limits");
  end

  logic                pin_meta, pin_sync;
  logic [DELAY-1:0]    hold_cnt;
  logic                tick;
  logic [TIMER_W-1:0]  timer;
  logic                timer_clr;
  state_t              state, state_next;
  logic                emit;
  logic [1:0]          emit_code;

  // Reset the synchronizer to the released level so a held button is seen as a fresh press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pin_meta <= 1'b1;
      pin_sync <= 1'b1;
      hold_cnt <= '0;
      pressed  <= 1'b0;
    end else begin
      pin_meta <= signal_pin;
      pin_sync <= pin_meta;
      if (~pin_sync == pressed) begin
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + DELAY'(1);
        if (&hold_cnt) pressed <= ~pressed;
      end
    end
  end

  button_gesture_tick_divider #(.TICK_LOG2(TICK_LOG2)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      if (timer_clr)             timer <= '0;
      else if (tick && !(&timer)) timer <= timer + TIMER_W'(1);
    end
  end

  // Level changes are tested before timer matches so they win a same-cycle tie.
  always_comb begin
    state_next = state;
    emit       = 1'b0;
    emit_code  = EV_CLICK;
    timer_clr  = 1'b0;
    case (state)
      IDLE: if (pressed) state_next = PRESS1;
      PRESS1: begin
        if (!pressed) state_next = GAP;
        else if (timer == LONG_T) begin
          state_next = HOLD;
          emit       = 1'b1;
          emit_code  = EV_LONG;
        end
      end
      GAP: begin
        if (pressed) state_next = PRESS2;
        else if (timer == GAP_T) begin
          state_next = IDLE;
          emit       = 1'b1;
          emit_code  = EV_CLICK;
        end
      end
      PRESS2: begin
        if (!pressed) begin
          state_next = IDLE;
          emit       = 1'b1;
          emit_code  = EV_DOUBLE;
        end else if (timer == LONG_T) begin
          state_next = HOLD;
          emit       = 1'b1;
          emit_code  = EV_LONG;
        end
      end
      HOLD: begin
        if (!pressed) state_next = IDLE;
`ifdef BUTTON_GESTURE_REPEAT_EN
        else if (timer == TIMER_W'(REPEAT_TICKS)) begin
          emit      = 1'b1;
          emit_code = EV_REPEAT;
          timer_clr = 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
    if (state_next != state) timer_clr = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      event_valid <= 1'b0;
      event_code  <= EV_CLICK;
      overflow    <= 1'b0;
    end else if (emit) begin
      if (!event_valid || event_ack) begin
        event_valid <= 1'b1;
        event_code  <= emit_code;
      end else begin
        overflow <= 1'b1;
      end
    end else if (event_ack) begin
      event_valid <= 1'b0;
    end
  end

endmodule
